cart_capture_buf: RTL and testbench

CART_CAPTURE_BUF -- requirements
Module: cart_capture_buf

---
 rtl/cart_pkg.sv | 21 ++
 rtl/cart_fifo.sv | 75 +++++++
 rtl/cart_capture_buf.sv | 75 +++++++
 tb/tb_cart_capture_buf.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared cartridge-capture types, also used by the upstream capture stage.
package cart_pkg;

   localparam int CART_ADDR_W = 32;
   localparam int CART_DATA_W = 32;

   typedef struct packed {
      logic [CART_ADDR_W-1:0] addr;
      logic [CART_DATA_W-1:0] data;
   } cart_entry_t;

   localparam int CART_ENTRY_W = $bits(cart_entry_t);

   // Inclusive, unsigned address window test.
   function automatic logic addr_in_window(input logic [CART_ADDR_W-1:0] addr,
                                           input logic [CART_ADDR_W-1:0] lo,
                                           input logic [CART_ADDR_W-1:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/cart_fifo.sv
// Show-ahead FIFO of cart entries with a registered head-of-queue output.
module cart_fifo
   import cart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  cart_entry_t            push_data_i,
   input  logic                   pop_i,
   output cart_entry_t            rd_data_o,
   output logic                   rd_valid_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o
);

   localparam int AW = $clog2(DEPTH);

   cart_entry_t mem [DEPTH];
   cart_entry_t rd_data_reg;
   logic        rd_valid_reg;
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic [AW:0] wr_ptr_next;
   logic [AW:0] rd_ptr_next;
   logic [AW:0] level;
   logic        push;
   logic        pop;

   // Pointers carry one extra bit so that full and empty differ.
   assign level       = wr_ptr_reg - rd_ptr_reg;
   assign full_o      = (level == (AW+1)'(DEPTH));
   assign pop         = pop_i & rd_valid_reg;
   assign push        = push_i & (~full_o | pop);
   assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
   assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (push && !flush_i) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data_i;
      end
   end

   // The head register preloads the entry that will be oldest after this edge;
   // an entry written this same edge into the head slot is taken from the input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else if (flush_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         rd_valid_reg <= (wr_ptr_next != rd_ptr_next);
         if (push && (wr_ptr_reg == rd_ptr_next)) begin
            rd_data_reg <= push_data_i;
         end else begin
            rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
         end
      end
   end

   assign rd_data_o  = rd_data_reg;
   assign rd_valid_o = rd_valid_reg;
   assign level_o    = level;

endmodule

// File: rtl/cart_capture_buf.sv
// Address-filtered capture buffer: window filter, drop statistics and clear in front of cart_fifo.
module cart_capture_buf
   import cart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [CART_ADDR_W-1:0]  addr_i,
   input  logic [CART_DATA_W-1:0]  data_i,
   input  logic                    valid_i,
   input  logic                    enable_i,
   input  logic [CART_ADDR_W-1:0]  addr_lo_i,
   input  logic [CART_ADDR_W-1:0]  addr_hi_i,
   input  logic                    clear_i,
   output logic [CART_ENTRY_W-1:0] rd_data_o,
   output logic                    rd_valid_o,
   input  logic                    rd_ready_i,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    overflow_o,
   output logic [15:0]             drop_cnt_o
);

   cart_entry_t push_entry;
   cart_entry_t fifo_rd_data;
   logic        qualify;
   logic        push;
   logic        pop;
   logic        full;
   logic        drop;
   logic        overflow_reg;
   logic [15:0] drop_cnt_reg;

   assign qualify    = valid_i & enable_i & addr_in_window(addr_i, addr_lo_i, addr_hi_i);
   assign pop        = rd_valid_o & rd_ready_i & ~clear_i;
   // A clear swallows any same-cycle push without counting it.
   assign push       = qualify & ~clear_i;
   assign drop       = push & full & ~pop;
   assign push_entry = '{addr: addr_i, data: data_i};

   cart_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (clear_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .rd_data_o   (fifo_rd_data),
      .rd_valid_o  (rd_valid_o),
      .level_o     (level_o),
      .full_o      (full)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (clear_i) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
      end
   end

   assign rd_data_o  = fifo_rd_data;
   assign overflow_o = overflow_reg;
   assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_cart_capture_buf.sv
// Directed bench for cart_capture_buf with a queue-based reference model checked every cycle.
module tb_cart_capture_buf;
   import cart_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        enable_i;
   logic [31:0] addr_lo_i;
   logic [31:0] addr_hi_i;
   logic        clear_i;
   logic [63:0] rd_data_o;
   logic        rd_valid_o;
   logic        rd_ready_i;
   logic [4:0]  level_o;
   logic        overflow_o;
   logic [15:0] drop_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] model_q[$];
   int          model_drop = 0;
   bit          model_ovf  = 1'b0;

   cart_capture_buf #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .enable_i   (enable_i),
      .addr_lo_i  (addr_lo_i),
      .addr_hi_i  (addr_hi_i),
      .clear_i    (clear_i),
      .rd_data_o  (rd_data_o),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready_i),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated by the FIFO's rules at every clock edge.
   always begin : model
      bit do_pop;
      bit qual;
      int sz;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         model_q.delete();
         model_drop = 0;
         model_ovf  = 1'b0;
      end else if (clear_i) begin
         model_q.delete();
         model_drop = 0;
         model_ovf  = 1'b0;
      end else begin
         sz     = model_q.size();
         do_pop = (sz > 0) && rd_ready_i;
         qual   = valid_i && enable_i && (addr_i >= addr_lo_i) && (addr_i <= addr_hi_i);
         if (do_pop) void'(model_q.pop_front());
         if (qual) begin
            if (sz < DEPTH || do_pop) begin
               model_q.push_back({addr_i, data_i});
            end else begin
               model_ovf = 1'b1;
               if (model_drop < 65535) model_drop++;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_rd_valid", 64'(rd_valid_o), 64'(model_q.size() != 0));
      check("cyc_level", 64'(level_o), 64'(model_q.size()));
      if (model_q.size() != 0) check("cyc_rd_data", rd_data_o, model_q[0]);
      check("cyc_overflow", 64'(overflow_o), 64'(model_ovf));
      check("cyc_drop_cnt", 64'(drop_cnt_o), 64'(model_drop));
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d);
      valid_i = v;
      addr_i  = a;
      data_i  = d;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_valid"}, 64'(rd_valid_o), 64'd0);
      check({tag, "_level"}, 64'(level_o), 64'd0);
      check({tag, "_rd_data"}, rd_data_o, 64'd0);
      check({tag, "_overflow"}, 64'(overflow_o), 64'd0);
      check({tag, "_drop_cnt"}, 64'(drop_cnt_o), 64'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      enable_i   = 1'b1;
      addr_lo_i  = 32'h1000_0000;
      addr_hi_i  = 32'h1FFF_FFFF;
      clear_i    = 1'b0;
      rd_ready_i = 1'b0;
      #1;
      check_zero("reset");
      step(2);
      reset_n = 1'b1;
      step(1);

      // Window filter: only the in-window strobe is stored
      drive(1'b1, 32'h1000_0040, 32'hA5A5_0001); step();
      drive(1'b1, 32'h0FFF_FFFC, 32'hA5A5_0002); step();
      drive(1'b1, 32'h2000_0000, 32'hA5A5_0003); step();
      valid_i = 1'b0;
      step();
      check("filter_level", 64'(level_o), 64'd1);
      check("filter_data", rd_data_o, 64'h1000_0040_A5A5_0001);
      check("filter_drop", 64'(drop_cnt_o), 64'd0);
      clear_i = 1'b1; step(); clear_i = 1'b0;

      // Latency and hold, window edges, enable gating
      check("lat_before", 64'(rd_valid_o), 64'd0);
      drive(1'b1, 32'h1000_0000, 32'hB000_0001); step();
      valid_i = 1'b0;
      check("lat_after", 64'(rd_valid_o), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_data", rd_data_o, 64'h1000_0000_B000_0001);
      end
      drive(1'b1, 32'h1FFF_FFFF, 32'hB000_0002); step();
      enable_i = 1'b0;
      drive(1'b1, 32'h1000_0100, 32'hB000_0003); step();
      enable_i = 1'b1;
      valid_i  = 1'b0;
      step();
      check("edge_level", 64'(level_o), 64'd2);
      rd_ready_i = 1'b1;
      check("edge_head", rd_data_o, 64'h1000_0000_B000_0001);
      step();
      check("edge_second", rd_data_o, 64'h1FFF_FFFF_B000_0002);
      step();
      rd_ready_i = 1'b0;
      check("edge_empty", 64'(level_o), 64'd0);

      // Overflow: 20 strobes into 16 entries, then drain in order
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 32'h1000_0000 + 32'(k * 4), 32'hD000_0000 + 32'(k));
         step();
      end
      valid_i = 1'b0;
      check("ovf_level", 64'(level_o), 64'd16);
      check("ovf_drop", 64'(drop_cnt_o), 64'd4);
      check("ovf_flag", 64'(overflow_o), 64'd1);
      rd_ready_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("drain_order", rd_data_o, {32'h1000_0000 + 32'(k * 4), 32'hD000_0000 + 32'(k)});
         step();
      end
      rd_ready_i = 1'b0;
      check("drain_empty", 64'(rd_valid_o), 64'd0);
      check("drain_sticky", 64'(overflow_o), 64'd1);
      clear_i = 1'b1; step(); clear_i = 1'b0;

      // Full FIFO with simultaneous push and pop
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 32'h1000_1000 + 32'(k * 4), 32'hE000_0000 + 32'(k));
         step();
      end
      drive(1'b1, 32'h1000_FFF0, 32'hEEEE_FFFF);
      rd_ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      check("pp_level", 64'(level_o), 64'd16);
      check("pp_drop", 64'(drop_cnt_o), 64'd0);
      for (int k = 1; k < 16; k++) begin
         check("pp_order", rd_data_o, {32'h1000_1000 + 32'(k * 4), 32'hE000_0000 + 32'(k)});
         step();
      end
      check("pp_last", rd_data_o, 64'h1000_FFF0_EEEE_FFFF);
      step();
      rd_ready_i = 1'b0;
      check("pp_empty", 64'(level_o), 64'd0);

      // Clear with level 7, drop count 3 and a same-cycle push
      for (int k = 0; k < 19; k++) begin
         drive(1'b1, 32'h1000_2000 + 32'(k * 4), 32'hC000_0000 + 32'(k));
         step();
      end
      valid_i    = 1'b0;
      rd_ready_i = 1'b1;
      step(9);
      rd_ready_i = 1'b0;
      check("pre_clr_level", 64'(level_o), 64'd7);
      check("pre_clr_drop", 64'(drop_cnt_o), 64'd3);
      clear_i = 1'b1;
      drive(1'b1, 32'h1000_3000, 32'h1234_5678);
      step();
      clear_i = 1'b0;
      valid_i = 1'b0;
      check("clr_level", 64'(level_o), 64'd0);
      check("clr_drop", 64'(drop_cnt_o), 64'd0);
      check("clr_ovf", 64'(overflow_o), 64'd0);
      check("clr_valid", 64'(rd_valid_o), 64'd0);
      step();
      check("clr_discard", 64'(level_o), 64'd0);

      // Asynchronous reset mid-burst
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'h1000_5000 + 32'(k * 4), 32'hF000_0000 + 32'(k));
         step();
      end
      check("burst_level", 64'(level_o), 64'd5);
      drive(1'b1, 32'h1000_5100, 32'hF000_00FF);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_zero("async_rst");
      step(2);
      #2 reset_n = 1'b1;
      valid_i = 1'b0;
      step();
      check("post_rst_level", 64'(level_o), 64'd0);
      drive(1'b1, 32'h1000_4000, 32'h0BAD_F00D);
      step();
      valid_i = 1'b0;
      check("post_rst_valid", 64'(rd_valid_o), 64'd1);
      check("post_rst_data", rd_data_o, 64'h1000_4000_0BAD_F00D);
      check("post_rst_level1", 64'(level_o), 64'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
